// File: rtl/serial_in_parallel_out_receiver.sv
// Framed serial-to-parallel receiver: collects DATA_WIDTH bits per frame and presents the word with valid/ready.
// Latency: word visible DATA_WIDTH cycles after the Start cycle; a word completing while the old one is unaccepted is dropped (sticky overrun).
module serial_in_parallel_out_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    input  logic                  Serial_Data_In,
    input  logic                  Data_Ready_In,
    output logic [DATA_WIDTH-1:0] Parallel_Data_Out,
    output logic                  Data_Valid_Out,
    output logic                  Busy_Out,
    output logic                  Overrun_Out
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_capture;
    logic                  w_complete;
    logic                  w_accept;
    logic                  w_busy;

    always_ff @(posedge Clk_In) begin
        if (Reset_In) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (Start_In) w_next_state = S_SHIFT;
            S_SHIFT: if (r_count == LAST_BIT) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == S_SHIFT);
        w_capture  = (r_state == S_SHIFT) || Start_In;
        w_complete = (r_state == S_SHIFT) && (r_count == LAST_BIT);
        w_accept   = r_valid && Data_Ready_In;
    end

    // Stale bits from the previous frame are fully shifted out by completion.
    assign w_shift_nxt = MSB_FIRST ? {r_shift[DATA_WIDTH-2:0], Serial_Data_In}
                                   : {Serial_Data_In, r_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_shift   <= '0;
            r_count   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) r_shift <= w_shift_nxt;

            if (w_complete)     r_count <= '0;
            else if (w_capture) r_count <= r_count + 1'b1;

            if (w_complete && (!r_valid || w_accept)) begin
                r_data  <= w_shift_nxt;
                r_valid <= 1'b1;
            end else if (w_complete) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Parallel_Data_Out = r_data;
    assign Data_Valid_Out    = r_valid;
    assign Busy_Out          = w_busy;
    assign Overrun_Out       = r_overrun;

endmodule
